mem8x8_initiator: RTL and testbench

Host-side access controller for the 8x8 memory array: the requesting end of the per-row sel/op → valid handshake that each memory row's control FSM answers. It accepts one read or write command at a time from the host over a valid/ready handshake. It then drives the one-hot row select, op strobe and write flag to the array and waits for the addressed row's valid. Finally it returns read data or a timeout error to the host.

---
 rtl/mem8x8_initiator_pkg.sv | 18 +
 rtl/mem8x8_initiator_onehot_dec.sv | 14 +
 rtl/mem8x8_initiator.sv | 105 ++++++++++
 tb/tb_mem8x8_initiator.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem8x8_initiator_pkg.sv
// Shared definitions for the 8x8 memory array initiator: state encoding,
// default widths and write-flag constants.
package mem8x8_initiator_pkg;

   localparam int ADDR_W_DEF = 3;
   localparam int DATA_W_DEF = 8;

   localparam logic WE_READ  = 1'b0;
   localparam logic WE_WRITE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/mem8x8_initiator_onehot_dec.sv
// Combinational row-address to one-hot row-select decoder.
module mem_onehot_dec #(
   parameter int ADDR_W = 3
) (
   input  logic [ADDR_W-1:0]      addr,
   output logic [2**ADDR_W-1:0]   onehot
);

   always_comb begin
      onehot       = '0;
      onehot[addr] = 1'b1;
   end

endmodule

// File: rtl/mem8x8_initiator.sv
// Host-side access controller for the 8x8 memory array: one command at a
// time, issues sel/op/we to the addressed row and waits for its valid.
//
// state    | meaning
// ST_IDLE  | ready for a host command
// ST_ISSUE | one-cycle op strobe to the selected row
// ST_WAIT  | waiting for mem_valid or timeout
// ST_DONE  | one-cycle response pulse to the host
module mem8x8_initiator
   import mem8x8_initiator_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic                    clkPE,
   input  logic                    rstN,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [DATA_W-1:0]       req_wdata,
   output logic                    rsp_valid,
   output logic [DATA_W-1:0]       rsp_rdata,
   output logic                    rsp_err,
   output logic [2**ADDR_W-1:0]    mem_sel,
   output logic                    mem_op,
   output logic                    mem_we,
   output logic [DATA_W-1:0]       mem_wdata,
   input  logic [DATA_W-1:0]       mem_rdata,
   input  logic                    mem_valid,
   output logic                    busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic [2**ADDR_W-1:0]    sel_dec;

   mem_onehot_dec #(.ADDR_W(ADDR_W)) u_dec (
      .addr   (req_addr),
      .onehot (sel_dec)
   );

   // Array-side outputs are loaded on the accept edge so they are already
   // registered and valid during the ISSUE cycle.
   always_ff @(posedge clkPE or negedge rstN) begin
      if (!rstN) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         req_ready <= 1'b0;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         mem_sel   <= '0;
         mem_op    <= 1'b0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         mem_op    <= 1'b0;
         case (state)
            ST_IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  state     <= ST_ISSUE;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  mem_sel   <= sel_dec;
                  mem_op    <= 1'b1;
                  mem_we    <= req_we;
                  mem_wdata <= (req_we == WE_READ) ? '0 : req_wdata;
               end
            end
            ST_ISSUE: begin
               cnt   <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               cnt <= cnt + CNT_W'(1);
               // A valid on the expiry edge still counts as success.
               if (mem_valid || (cnt == CNT_LAST)) begin
                  state     <= ST_DONE;
                  rsp_valid <= 1'b1;
                  rsp_err   <= ~mem_valid;
                  rsp_rdata <= (mem_valid && (mem_we == WE_READ)) ? mem_rdata : '0;
                  mem_sel   <= '0;
                  mem_we    <= 1'b0;
                  mem_wdata <= '0;
               end
            end
            ST_DONE: begin
               state     <= ST_IDLE;
               busy      <= 1'b0;
               req_ready <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem8x8_initiator.sv
// Randomized bench for mem8x8_initiator against a transaction-timeline model.
module tb_mem8x8_initiator;

   localparam int AW = 3;
   localparam int DW = 8;
   localparam int TO = 15;

   logic          clkPE = 1'b0;
   logic          rstN  = 1'b0;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid, rsp_err, mem_op, mem_we, mem_valid, busy;
   logic [DW-1:0] rsp_rdata, mem_wdata, mem_rdata;
   logic [7:0]    mem_sel;

   always #5 clkPE = ~clkPE;

   mem8x8_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(4)) dut (
      .clkPE     (clkPE),
      .rstN      (rstN),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_sel   (mem_sel),
      .mem_op    (mem_op),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_valid (mem_valid),
      .busy      (busy)
   );

   typedef struct {
      logic       we;
      logic [2:0] addr;
      logic [7:0] wdata;
      int         d;       // WAIT cycle index of the row response; >= TO means never
      logic [7:0] rdata;
      int         tag;     // nonzero for the hand-checked transactions
   } cmd_t;

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   n_rst = 0;
   int   t_acc, t_done;
   bit   active, h_valid, in_wait;
   cmd_t dir_q[$];
   cmd_t host_cmd, cur;
   logic [7:0] e_rdata, new_rdata, e_sel, e_wd, one8;
   logic       e_err, new_err, e_op, e_we, e_rv, e_busy, e_rdy;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_sel"},   32'(mem_sel),   32'h0);
      chk({nm, "_op"},    32'(mem_op),    32'h0);
      chk({nm, "_we"},    32'(mem_we),    32'h0);
      chk({nm, "_wdata"}, 32'(mem_wdata), 32'h0);
      chk({nm, "_rv"},    32'(rsp_valid), 32'h0);
      chk({nm, "_rdata"}, 32'(rsp_rdata), 32'h0);
      chk({nm, "_err"},   32'(rsp_err),   32'h0);
      chk({nm, "_busy"},  32'(busy),      32'h0);
      chk({nm, "_ready"}, 32'(req_ready), 32'h0);
   endtask

   initial begin
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      mem_valid = 1'b0; mem_rdata = '0;
      one8 = 8'h01;
      dir_q.push_back('{we:1'b1, addr:3'd5, wdata:8'hA7, d:0,  rdata:8'hFF, tag:1});
      dir_q.push_back('{we:1'b0, addr:3'd2, wdata:8'h11, d:2,  rdata:8'h3C, tag:2});
      dir_q.push_back('{we:1'b0, addr:3'd7, wdata:8'h00, d:99, rdata:8'h00, tag:3});
      dir_q.push_back('{we:1'b0, addr:3'd3, wdata:8'h00, d:TO-1, rdata:8'h5A, tag:4});
      active = 0; h_valid = 0; e_rdata = '0; e_err = 1'b0;
      new_rdata = '0; new_err = 1'b0; t_acc = 0; t_done = 0;

      repeat (3) @(posedge clkPE);
      #1;
      check_zero("reset");
      rstN = 1'b1;

      while (cyc < 700) begin
         @(posedge clkPE);
         #1;
         cyc++;
         if (active && cyc > t_done) active = 0;
         if (active && cyc == t_done) begin
            e_rdata = new_rdata;
            e_err   = new_err;
         end

         e_sel = '0; e_op = 0; e_we = 0; e_wd = '0; e_rv = 0; e_busy = 0; e_rdy = 1;
         if (active) begin
            e_rdy  = 0;
            e_busy = 1;
            if (cyc == t_done) e_rv = 1;
            else begin
               e_sel = one8 << cur.addr;
               e_op  = (cyc == t_acc + 1);
               e_we  = cur.we;
               e_wd  = cur.we ? cur.wdata : 8'h00;
            end
         end
         chk("mem_sel",   32'(mem_sel),   32'(e_sel));
         chk("mem_op",    32'(mem_op),    32'(e_op));
         chk("mem_we",    32'(mem_we),    32'(e_we));
         chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
         chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
         chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
         chk("rsp_err",   32'(rsp_err),   32'(e_err));
         chk("busy",      32'(busy),      32'(e_busy));
         chk("req_ready", 32'(req_ready), 32'(e_rdy));

         if (active) begin
            case (cur.tag)
               1: begin
                  if (cyc == t_acc + 1) begin
                     chk("lit_wr_sel", 32'(mem_sel), 32'h20);
                     chk("lit_wr_wdata", 32'(mem_wdata), 32'hA7);
                  end
                  if (cyc == t_acc + 3) begin
                     chk("lit_wr_rv", 32'(rsp_valid), 32'h1);
                     chk("lit_wr_rdata", 32'(rsp_rdata), 32'h0);
                  end
               end
               2: begin
                  if (cyc == t_acc + 1) begin
                     chk("lit_rd_sel", 32'(mem_sel), 32'h04);
                     chk("lit_rd_we", 32'(mem_we), 32'h0);
                  end
                  if (cyc == t_acc + 5) begin
                     chk("lit_rd_rv", 32'(rsp_valid), 32'h1);
                     chk("lit_rd_rdata", 32'(rsp_rdata), 32'h3C);
                  end
               end
               3: begin
                  if (cyc == t_acc + 16) chk("lit_to_sel16", 32'(mem_sel), 32'h80);
                  if (cyc == t_acc + 17) begin
                     chk("lit_to_rv", 32'(rsp_valid), 32'h1);
                     chk("lit_to_err", 32'(rsp_err), 32'h1);
                     chk("lit_to_sel17", 32'(mem_sel), 32'h0);
                  end
               end
               4: begin
                  if (cyc == t_acc + 17) begin
                     chk("lit_race_rv", 32'(rsp_valid), 32'h1);
                     chk("lit_race_err", 32'(rsp_err), 32'h0);
                     chk("lit_race_rdata", 32'(rsp_rdata), 32'h5A);
                  end
               end
               default: ;
            endcase
         end

         in_wait = active && (cyc >= t_acc + 2) && (cyc < t_done);

         // asynchronous reset in the middle of a WAIT
         if (in_wait && cur.tag == 0 && dir_q.size() == 0 && n_rst < 3 &&
             ($urandom_range(0, 9) == 0 || (n_rst == 0 && cyc > 400))) begin
            rstN = 1'b0;
            #1;
            check_zero("midrst");
            rstN = 1'b1;
            req_valid = 1'b0;
            mem_valid = 1'b0;
            h_valid = 0;
            active = 0;
            e_rdata = '0;
            e_err = 1'b0;
            n_rst++;
            continue;
         end

         mem_rdata = 8'($urandom);
         if (in_wait) begin
            if (cur.d <= TO - 1 && cyc == t_acc + 2 + cur.d) begin
               mem_valid = 1'b1;
               if (cur.tag != 0) mem_rdata = cur.rdata;
               new_rdata = cur.we ? 8'h00 : mem_rdata;
            end else begin
               mem_valid = 1'b0;
            end
         end else begin
            mem_valid = ($urandom_range(0, 3) == 0);
         end

         if (!h_valid) begin
            if (dir_q.size() > 0) begin
               host_cmd = dir_q.pop_front();
               h_valid = 1;
            end else if ($urandom_range(0, 2) == 0) begin
               host_cmd.we    = 1'($urandom);
               host_cmd.addr  = 3'($urandom);
               host_cmd.wdata = 8'($urandom);
               host_cmd.d     = $urandom_range(0, 19);
               host_cmd.rdata = 8'h00;
               host_cmd.tag   = 0;
               h_valid = 1;
            end
         end
         req_valid = h_valid;
         req_we    = host_cmd.we;
         req_addr  = host_cmd.addr;
         req_wdata = host_cmd.wdata;

         if (h_valid && !active) begin
            active = 1;
            t_acc  = cyc;
            cur    = host_cmd;
            h_valid = 0;
            if (cur.d <= TO - 1) begin
               t_done  = t_acc + 3 + cur.d;
               new_err = 1'b0;
            end else begin
               t_done    = t_acc + 2 + TO;
               new_err   = 1'b1;
               new_rdata = 8'h00;
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
